hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Central hazard and stall controller for the 5-stage pipeline.
- Drives stall/flush for the F, D, E, M and W pipeline registers.
- Drives the D/E forwarding selects.
- Sequences multi-cycle events: data-memory wait with timeout, and the multi-cycle mul/div unit (MDU) busy window.
- Sits beside the datapath and feeds stallD/pcsrcD-style controls into the IF/ID register and the downstream stage registers.

Parameters:
MDU_LATENCY, 32, cycles an MDU op occupies the unit (≥2)
MEM_TIMEOUT, 64, max consecutive dmem wait cycles before error
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
rsD, rtD  in  5  D-stage source regs
rsE, rtE  in  5  E-stage source regs
writeregE, writeregM, writeregW  in  5  destination regs
regwriteE, regwriteM, regwriteW  in  1  stage writes register file
memtoregE, memtoregM  in  1  stage instruction is a load
branchD  in  1  D-stage branch
pcsrcD  in  1  branch/jump taken in D
mdu_startE  in  1  MDU op in E requests start
mdu_useD  in  1  D instruction reads HI/LO or is an MDU op
dmem_reqM, dmem_readyM  in  1  data-memory request / ready
stallF, stallD, stallE, stallM  out  1  hold stage register
flushD, flushE, flushW  out  1  clear stage register to bubble
forwardAD, forwardBD  out  1  D-stage compare forward from M
forwardAE, forwardBE  out  2  00 regfile, 01 from W, 10 from M
mdu_busy  out  1  MDU window active
mdu_done  out  1  one-cycle pulse at MDU completion
mem_err  out  1  sticky dmem timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stallF=1

Behaviour:
- Reset state:
  - FSM=RUN; mdu counter=0; mdu_busy=0, mdu_done=0, mem_err=0, stall_cycles=0.
  - All combinational outputs evaluate to 0 for all-zero inputs.
- Forwarding (combinational; a register number of 0 never matches):
  - forwardAE=10 if regwriteM and writeregM==rsE; else 01 if regwriteW and writeregW==rsE; else 00.
  - forwardBE: same rule with rtE.
  - forwardAD = regwriteM and writeregM==rsD.
  - forwardBD = regwriteM and writeregM==rtD.
- Hazard terms:
  - lwstall = memtoregE and rtE!=0 and (rtE==rsD or rtE==rtD).
  - brstall = branchD and ((regwriteE and writeregE in {rsD,rtD}) or (memtoregM and writeregM in {rsD,rtD})); writereg!=0.
  - mdustall = mdu_busy and mdu_useD.
  - memstall = dmem_reqM and not dmem_readyM and FSM!=MEM_ERR.
- Output resolution, highest priority first:
  - memstall: stallF=stallD=stallE=stallM=1; flushW=1; flushD=flushE=0.
  - else lwstall|brstall|mdustall: stallF=stallD=1; flushE=1.
  - else all stalls 0.
  - flushD = pcsrcD and not stallD.
- Memory FSM (RUN, MEM_WAIT, MEM_ERR):
  - RUN→MEM_WAIT when memstall; wait counter loads 1.
  - MEM_WAIT→RUN when dmem_readyM=1.
  - MEM_WAIT: counter increments each cycle; →MEM_ERR when counter==MEM_TIMEOUT.
  - MEM_ERR: mem_err=1 (sticky); memstall is forced 0 so the pipeline drains; leaves MEM_ERR only on reset.
- MDU sequencing:
  - Start condition: mdu_startE and not memstall and not mdu_busy. On start, counter loads MDU_LATENCY-1 and mdu_busy=1 from the next cycle.
  - Counter decrements each cycle, including during memstall.
  - At counter==0 while busy: mdu_busy clears and mdu_done pulses 1 cycle.
  - mdu_startE while busy is ignored: mdu_useD stalls any second MDU op in D.
- stall_cycles: increments on every cycle with stallF=1; saturates at all-ones.
- Async reset mid-wait or mid-MDU returns everything to reset values immediately.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - fwd_sel_t (2-bit enum: FWD_RF, FWD_W, FWD_M)
  - mem_state_t (RUN, MEM_WAIT, MEM_ERR)
  - REG_ZERO constant
- One natural sub-module: mdu_window_ctr (load/decrement counter producing mdu_busy/mdu_done).
- Forwarding and the mem FSM stay in the top module.

Test Plan:
1. Forwarding: regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 → forwardAE=10. Set writeregM=0 → forwardAE=01.
2. Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1 for 1 cycle. With pcsrcD=1 in the same cycle, flushD=0.
3. Memory wait: dmem_reqM=1, dmem_readyM=0 for 3 cycles, then 1 → stallF/D/E/M=1 and flushW=1 for 3 cycles, FSM back to RUN, stall_cycles=3.
4. Memory timeout: MEM_TIMEOUT=4, ready held 0 → mem_err=1 after 4 wait cycles; stalls drop; mem_err stays 1 until rst_n=0.
5. MDU window: MDU_LATENCY=4, mdu_startE pulse → mdu_busy=1 for 4 cycles, then mdu_done pulse. mdu_useD=1 during the window → stallD=1. Concurrent memstall does not extend the window.
6. Async reset: assert rst_n=0 mid-MDU and mid-MEM_WAIT → all outputs 0 immediately; stall_cycles=0.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
//   fwd_sel_t   : forwarding mux select (register file, W stage, M stage)
//   mem_state_t : data-memory wait sequencer states
//   REG_ZERO    : architectural zero register, never a forwarding/hazard source
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ERR  = 2'b10
    } mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a written register aliases a source register; r0 never aliases.
    function automatic logic reg_match(input logic [4:0] wr, input logic [4:0] src);
        return (wr != REG_ZERO) && (wr == src);
    endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle of datapath-status inputs and pipeline-control outputs between the
// datapath (master) and the hazard sequencer (slave).
//   Datapath -> sequencer : register numbers, regwrite/memtoreg flags, branch,
//                           pcsrcD, MDU start/use, dmem request/ready
//   Sequencer -> datapath : stall/flush per stage, forwarding selects, MDU
//                           status, sticky memory error, stall-cycle count
interface hazard_sequencer_if #(parameter int CNT_W = 16);
    import pipe_ctrl_pkg::*;

    logic [4:0]       rsD, rtD, rsE, rtE;
    logic [4:0]       writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM;
    logic             branchD, pcsrcD;
    logic             mdu_startE, mdu_useD;
    logic             dmem_reqM, dmem_readyM;

    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             forwardAD, forwardBD;
    fwd_sel_t         forwardAE, forwardBE;
    logic             mdu_busy, mdu_done, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, pcsrcD, mdu_startE, mdu_useD, dmem_reqM, dmem_readyM,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE,
               mdu_busy, mdu_done, mem_err, stall_cycles
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, pcsrcD, mdu_startE, mdu_useD, dmem_reqM, dmem_readyM,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               forwardAD, forwardBD, forwardAE, forwardBE,
               mdu_busy, mdu_done, mem_err, stall_cycles
    );

endinterface

// File: rtl/hazard_sequencer_mdu.sv
// MDU occupancy window: a start loads LATENCY-1 and the unit reports busy for
// LATENCY cycles, then pulses done for one cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted only while idle
//   busy       : window active (registered)
//   done       : one-cycle completion pulse, the cycle after the window (registered)
module mdu_window_ctr #(
    parameter int LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done
);
    localparam int CW = $clog2(LATENCY);

    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;

    // Window counter; it keeps running regardless of pipeline stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                if (cnt_r == '0) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r - CW'(1);
                end
            end else if (start) begin
                cnt_r  <= CW'(LATENCY - 1);
                busy_r <= 1'b1;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/hazard_sequencer.sv
// Central hazard/stall controller for the 5-stage pipeline.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : hazard_sequencer_if slave port (datapath status in,
//                stall/flush/forward controls and status out)
// Forwarding and stall resolution are combinational; the memory-wait FSM,
// sticky error, stall counter and MDU window are registered.
module hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_sequencer_if.slave   bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_t       state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             lwstall_s, brstall_s, mdustall_s, memstall_s;
    logic             mdu_start_s, mdu_busy_s, mdu_done_s;
    fwd_sel_t         fwd_ae_s, fwd_be_s;

    // E-stage forwarding selects: the younger M result wins over W.
    always_comb begin
        fwd_ae_s = FWD_RF;
        fwd_be_s = FWD_RF;
        if (bus.regwriteM && reg_match(bus.writeregM, bus.rsE)) begin
            fwd_ae_s = FWD_M;
        end else if (bus.regwriteW && reg_match(bus.writeregW, bus.rsE)) begin
            fwd_ae_s = FWD_W;
        end else begin
            fwd_ae_s = FWD_RF;
        end
        if (bus.regwriteM && reg_match(bus.writeregM, bus.rtE)) begin
            fwd_be_s = FWD_M;
        end else if (bus.regwriteW && reg_match(bus.writeregW, bus.rtE)) begin
            fwd_be_s = FWD_W;
        end else begin
            fwd_be_s = FWD_RF;
        end
    end

    // Hazard terms; a memory wait is suppressed once the error state is reached
    // so the pipeline can drain.
    always_comb begin
        lwstall_s  = bus.memtoregE && (bus.rtE != REG_ZERO) &&
                     ((bus.rtE == bus.rsD) || (bus.rtE == bus.rtD));
        brstall_s  = bus.branchD &&
                     ((bus.regwriteE && (reg_match(bus.writeregE, bus.rsD) ||
                                         reg_match(bus.writeregE, bus.rtD))) ||
                      (bus.memtoregM && (reg_match(bus.writeregM, bus.rsD) ||
                                         reg_match(bus.writeregM, bus.rtD))));
        mdustall_s = mdu_busy_s && bus.mdu_useD;
        memstall_s = bus.dmem_reqM && !bus.dmem_readyM && (state_r != MEM_ERR);
    end

    // Stall/flush resolution: a memory wait freezes everything up to M and
    // bubbles W; a D-stage hazard freezes F/D and bubbles E.
    always_comb begin
        bus.stallF = 1'b0;
        bus.stallD = 1'b0;
        bus.stallE = 1'b0;
        bus.stallM = 1'b0;
        bus.flushE = 1'b0;
        bus.flushW = 1'b0;
        if (memstall_s) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
            bus.stallM = 1'b1;
            bus.flushW = 1'b1;
        end else if (lwstall_s || brstall_s || mdustall_s) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.flushE = 1'b1;
        end else begin
            bus.stallF = 1'b0;
        end
        // A stalled D holds the branch, so its redirect must not squash it yet.
        bus.flushD = bus.pcsrcD && !bus.stallD;
    end

    // Memory-wait FSM next state and wait counter.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            RUN: begin
                if (memstall_s) begin
                    state_nxt_s    = MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_W'(1);
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_readyM) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
                    state_nxt_s = MEM_ERR;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            MEM_ERR: state_nxt_s = MEM_ERR;
            default: state_nxt_s = RUN;
        endcase
    end

    // FSM state, sticky error flag and saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            wait_cnt_r  <= '0;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            if (state_nxt_s == MEM_ERR) begin
                mem_err_r <= 1'b1;
            end
            if (bus.stallF && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    // A start during a memory wait would be lost with the frozen E stage.
    assign mdu_start_s = bus.mdu_startE && !memstall_s && !mdu_busy_s;

    mdu_window_ctr #(.LATENCY(MDU_LATENCY)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start_s),
        .busy  (mdu_busy_s),
        .done  (mdu_done_s)
    );

    assign bus.forwardAE    = fwd_ae_s;
    assign bus.forwardBE    = fwd_be_s;
    assign bus.forwardAD    = bus.regwriteM && reg_match(bus.writeregM, bus.rsD);
    assign bus.forwardBD    = bus.regwriteM && reg_match(bus.writeregM, bus.rtD);
    assign bus.mdu_busy     = mdu_busy_s;
    assign bus.mdu_done     = mdu_done_s;
    assign bus.mem_err      = mem_err_r;
    assign bus.stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_hazard_sequencer;
    localparam int LAT = 4;
    localparam int TMO = 4;
    localparam int CW  = 6;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_sequencer_if #(.CNT_W(CW)) bus ();

    hazard_sequencer #(.MDU_LATENCY(LAT), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic rwE, rwM, rwW, mtrE, mtrM, brD, pcD, startE, useD, req, rdy;
    } in_t;

    typedef struct {
        in_t        i;
        string      name;
        logic [3:0] st;   // {F,D,E,M}
        logic [2:0] fl;   // {D,E,W}
        logic [1:0] fd;   // {AD,BD}
        logic [1:0] ae, be;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: remaining busy cycles, done pulse, consecutive memory
    // stall cycles, error flag, stall-cycle count.
    int m_left, m_consec, m_stalls;
    bit m_done, m_err;

    in_t  z, t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        bus.rsD = v.rsD; bus.rtD = v.rtD; bus.rsE = v.rsE; bus.rtE = v.rtE;
        bus.writeregE = v.wE; bus.writeregM = v.wM; bus.writeregW = v.wW;
        bus.regwriteE = v.rwE; bus.regwriteM = v.rwM; bus.regwriteW = v.rwW;
        bus.memtoregE = v.mtrE; bus.memtoregM = v.mtrM;
        bus.branchD = v.brD; bus.pcsrcD = v.pcD;
        bus.mdu_startE = v.startE; bus.mdu_useD = v.useD;
        bus.dmem_reqM = v.req; bus.dmem_readyM = v.rdy;
    endtask

    function automatic bit hit(input logic [4:0] w, input logic [4:0] s);
        return (w != 5'd0) && (w == s);
    endfunction

    task automatic model_comb(input in_t v, output logic [3:0] st, output logic [2:0] fl,
                              output logic [1:0] fd, output logic [1:0] ae,
                              output logic [1:0] be, output bit ms);
        bit lw, br, md;
        ae = (v.rwM && hit(v.wM, v.rsE)) ? 2'd2 : (v.rwW && hit(v.wW, v.rsE)) ? 2'd1 : 2'd0;
        be = (v.rwM && hit(v.wM, v.rtE)) ? 2'd2 : (v.rwW && hit(v.wW, v.rtE)) ? 2'd1 : 2'd0;
        fd = {v.rwM && hit(v.wM, v.rsD), v.rwM && hit(v.wM, v.rtD)};
        lw = v.mtrE && (v.rtE != 5'd0) && ((v.rtE == v.rsD) || (v.rtE == v.rtD));
        br = v.brD && ((v.rwE && (hit(v.wE, v.rsD) || hit(v.wE, v.rtD))) ||
                       (v.mtrM && (hit(v.wM, v.rsD) || hit(v.wM, v.rtD))));
        md = (m_left > 0) && v.useD;
        ms = v.req && !v.rdy && !m_err;
        if (ms) begin
            st = 4'b1111; fl = 3'b001;
        end else if (lw || br || md) begin
            st = 4'b1100; fl = 3'b010;
        end else begin
            st = 4'b0000; fl = 3'b000;
        end
        fl[2] = v.pcD && !st[2];
    endtask

    // Compare every output with the model, then advance the model and clock.
    task automatic check_adv(input in_t v);
        logic [3:0] est; logic [2:0] efl; logic [1:0] efd, eae, ebe; bit ms, was_busy;
        model_comb(v, est, efl, efd, eae, ebe, ms);
        chk("stalls", 32'({bus.stallF, bus.stallD, bus.stallE, bus.stallM}), 32'(est));
        chk("flushes", 32'({bus.flushD, bus.flushE, bus.flushW}), 32'(efl));
        chk("fwd_d", 32'({bus.forwardAD, bus.forwardBD}), 32'(efd));
        chk("fwd_ae", 32'(bus.forwardAE), 32'(eae));
        chk("fwd_be", 32'(bus.forwardBE), 32'(ebe));
        chk("mdu_busy", 32'(bus.mdu_busy), 32'(m_left > 0));
        chk("mdu_done", 32'(bus.mdu_done), 32'(m_done));
        chk("mem_err", 32'(bus.mem_err), 32'(m_err));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
        if (est[3]) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
        if (ms) begin
            m_consec++;
            if (m_consec == TMO + 1) m_err = 1'b1;
        end else begin
            m_consec = 0;
        end
        was_busy = (m_left > 0);
        m_done = was_busy && (m_left == 1);
        if (was_busy) m_left--;
        else if (v.startE && !ms) m_left = LAT;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input in_t v);
        drive(v);
        #3;
        check_adv(v);
    endtask

    // Asynchronous reset taken wherever the caller currently is in the cycle.
    task automatic do_reset();
        drive(z);
        rst_n = 1'b0;
        #1;
        chk("rst_regs", 32'({bus.mdu_busy, bus.mdu_done, bus.mem_err, bus.stall_cycles}), 32'd0);
        chk("rst_comb", 32'({bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushD,
                             bus.flushE, bus.flushW, bus.forwardAD, bus.forwardBD,
                             bus.forwardAE, bus.forwardBE}), 32'd0);
        m_left = 0; m_consec = 0; m_stalls = 0; m_done = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input in_t v, input string nm, input logic [3:0] st, input logic [2:0] fl,
                       input logic [1:0] fd, input logic [1:0] ae, input logic [1:0] be);
        vec_t e;
        e.i = v; e.name = nm; e.st = st; e.fl = fl; e.fd = fd; e.ae = ae; e.be = be;
        tbl.push_back(e);
    endtask

    initial begin
        int busy_n, done_n, done_at;
        z = '{default: '0};

        // Directed vectors (hand-derived expectations)
        t = z; t.rwM = 1; t.wM = 5; t.rwW = 1; t.wW = 5; t.rsE = 5;
        add(t, "fwd_m_over_w", 4'b0000, 3'b000, 2'b00, 2'd2, 2'd0);
        t.wM = 0;
        add(t, "fwd_w_when_m_r0", 4'b0000, 3'b000, 2'b00, 2'd1, 2'd0);
        t = z; t.rwW = 1; t.wW = 7; t.rtE = 7;
        add(t, "fwd_be_w", 4'b0000, 3'b000, 2'b00, 2'd0, 2'd1);
        t = z; t.rwM = 1; t.wM = 3; t.rsE = 3; t.rtE = 3; t.rsD = 3;
        add(t, "fwd_both_m", 4'b0000, 3'b000, 2'b10, 2'd2, 2'd2);
        t = z; t.wM = 3; t.rsE = 3; t.rtD = 3;
        add(t, "fwd_no_regwrite", 4'b0000, 3'b000, 2'b00, 2'd0, 2'd0);
        t = z; t.mtrE = 1; t.rtE = 8; t.rsD = 8; t.pcD = 1;
        add(t, "loaduse_pcsrc", 4'b1100, 3'b010, 2'b00, 2'd0, 2'd0);
        t = z; t.mtrE = 1; t.pcD = 1;
        add(t, "loaduse_r0", 4'b0000, 3'b100, 2'b00, 2'd0, 2'd0);
        t = z; t.brD = 1; t.rwE = 1; t.wE = 9; t.rtD = 9;
        add(t, "brstall_e", 4'b1100, 3'b010, 2'b00, 2'd0, 2'd0);
        t = z; t.brD = 1; t.mtrM = 1; t.wM = 4; t.rsD = 4;
        add(t, "brstall_m_load", 4'b1100, 3'b010, 2'b00, 2'd0, 2'd0);
        t = z; t.brD = 1; t.rwE = 1;
        add(t, "br_r0", 4'b0000, 3'b000, 2'b00, 2'd0, 2'd0);
        t = z; t.req = 1; t.mtrE = 1; t.rtE = 8; t.rsD = 8; t.pcD = 1;
        add(t, "memstall_wins", 4'b1111, 3'b001, 2'b00, 2'd0, 2'd0);
        t = z; t.req = 1; t.rdy = 1;
        add(t, "mem_ready", 4'b0000, 3'b000, 2'b00, 2'd0, 2'd0);

        #2;
        do_reset();
        foreach (tbl[k]) begin
            drive(tbl[k].i);
            #3;
            chk({"tbl_st_", tbl[k].name}, 32'({bus.stallF, bus.stallD, bus.stallE, bus.stallM}), 32'(tbl[k].st));
            chk({"tbl_fl_", tbl[k].name}, 32'({bus.flushD, bus.flushE, bus.flushW}), 32'(tbl[k].fl));
            chk({"tbl_fd_", tbl[k].name}, 32'({bus.forwardAD, bus.forwardBD}), 32'(tbl[k].fd));
            chk({"tbl_ae_", tbl[k].name}, 32'(bus.forwardAE), 32'(tbl[k].ae));
            chk({"tbl_be_", tbl[k].name}, 32'(bus.forwardBE), 32'(tbl[k].be));
            check_adv(tbl[k].i);
        end

        // Memory wait of three cycles, then ready
        do_reset();
        t = z; t.req = 1;
        repeat (3) step(t);
        t.rdy = 1;
        step(t);
        chk("memwait_stall_cycles", 32'(bus.stall_cycles), 32'd3);

        // Memory timeout: stall for the entry cycle plus TMO wait cycles
        do_reset();
        t = z; t.req = 1;
        repeat (TMO + 1) step(t);
        chk("timeout_err", 32'(bus.mem_err), 32'd1);
        chk("timeout_drain", 32'(bus.stallF), 32'd0);
        repeat (3) step(t);
        t.rdy = 1;
        repeat (2) step(t);
        chk("timeout_sticky", 32'(bus.mem_err), 32'd1);
        chk("timeout_stall_cycles", 32'(bus.stall_cycles), 32'(TMO + 1));

        // MDU window with use-stall, ignored restart and concurrent memstall
        do_reset();
        t = z; t.startE = 1;
        step(t);
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            if (bus.mdu_busy) busy_n++;
            if (bus.mdu_done) begin
                done_n++;
                done_at = i;
            end
            t = z; t.useD = 1;
            t.startE = (i == 2);
            t.req = (i == 1 || i == 2);
            t.rdy = (i == 2);
            drive(t);
            #3;
            if (i == 0) chk("mdu_use_stallD", 32'(bus.stallD), 32'd1);
            check_adv(t);
        end
        chk("mdu_busy_len", 32'(busy_n), 32'(LAT));
        chk("mdu_done_cnt", 32'(done_n), 32'd1);
        chk("mdu_done_pos", 32'(done_at), 32'(LAT));

        // Asynchronous reset mid-MDU and mid-wait
        do_reset();
        t = z; t.startE = 1;
        step(t);
        t = z; t.req = 1;
        repeat (2) step(t);
        chk("pre_rst_busy", 32'(bus.mdu_busy), 32'd1);
        #2;
        do_reset();

        // Stall-counter saturation
        t = z; t.mtrE = 1; t.rtE = 2; t.rtD = 2;
        repeat (SAT + 7) step(t);
        chk("stall_cnt_sat", 32'(bus.stall_cycles), 32'(SAT));

        // Randomized traffic against the model
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                t.rsD = 5'($urandom_range(0, 7)); t.rtD = 5'($urandom_range(0, 7));
                t.rsE = 5'($urandom_range(0, 7)); t.rtE = 5'($urandom_range(0, 7));
                t.wE = 5'($urandom_range(0, 7)); t.wM = 5'($urandom_range(0, 7));
                t.wW = 5'($urandom_range(0, 7));
                t.rwE = 1'($urandom); t.rwM = 1'($urandom); t.rwW = 1'($urandom);
                t.mtrE = 1'($urandom); t.mtrM = 1'($urandom);
                t.brD = 1'($urandom); t.pcD = 1'($urandom);
                t.startE = ($urandom_range(0, 3) == 0);
                t.useD = 1'($urandom);
                t.req = 1'($urandom); t.rdy = 1'($urandom);
                // A pending memory access keeps its request until served.
                if (m_consec > 0 && !t.rdy) t.req = 1'b1;
                step(t);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
